// File: rtl/sl_fifo_pkg.sv
// Shared definitions for the SL FIFO command/response path (bus side and channel side).
package sl_fifo_pkg;

    localparam int unsigned HMB    = 33;
    localparam int unsigned LMB    = 32;
    localparam int unsigned WORD_W = 34;

    localparam logic [1:0] MOD_CONFIG  = 2'd0;
    localparam logic [1:0] MOD_DATA    = 2'd1;
    localparam logic [1:0] MOD_STATUS  = 2'd2;
    localparam logic [1:0] MOD_CHANNEL = 2'd3;

    localparam logic [1:0] ERR_OK       = 2'd0;
    localparam logic [1:0] ERR_TIMEOUT  = 2'd1;
    localparam logic [1:0] ERR_MODIFIER = 2'd2;
    localparam logic [1:0] ERR_ILLEGAL  = 2'd3;

    typedef enum logic {StIdle, StAccess} state_e;

endpackage

// File: rtl/apb_sl_fifo_port_if.sv
// APB3 bus signals between the system bus and the SL FIFO port.
interface apb_sl_fifo_port_if;

    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [3:0]  paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
        output prdata, pready, pslverr
    );

endinterface

// File: rtl/apb_sl_wait_timer.sv
// Wait-state counter for APB ACCESS: clear, saturating increment, terminal count at TIMEOUT.
// Only built when APB_SL_TIMEOUT_EN is defined.
`ifdef APB_SL_TIMEOUT_EN
module apb_sl_wait_timer #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic inc,
    output logic done
);

    localparam int unsigned TO_W = $clog2(TIMEOUT + 1);

    logic [TO_W-1:0] cnt_q, cnt_d;

    assign done = (cnt_q == TO_W'(TIMEOUT));

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (inc && !done) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule
`endif

// File: rtl/apb_sl_fifo_port.sv
// APB3 slave that pushes writes into the SL command FIFO and pops reads from the response FIFO.
// Define APB_SL_TIMEOUT_EN to enable the wait-state timeout (error code 1).
module apb_sl_fifo_port
    import sl_fifo_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    apb_sl_fifo_port_if.slave apb,
    input  logic              fifo_write_full,
    output logic [WORD_W-1:0] fifo_write_data,
    output logic              fifo_write_inc,
    input  logic              fifo_read_empty,
    input  logic [WORD_W-1:0] fifo_read_data,
    output logic              fifo_read_inc,
    output logic [1:0]        last_err
);

    state_e     state_q, state_d;
    logic [1:0] last_err_q, last_err_d;

`ifdef APB_SL_TIMEOUT_EN
    logic wait_clr, wait_inc, wait_done;

    apb_sl_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .clk   (clk),
        .rst   (rst),
        .clear (wait_clr),
        .inc   (wait_inc),
        .done  (wait_done)
    );
`endif

    timeout_min_a: assert property (@(posedge clk) TIMEOUT >= 1);

    assign fifo_write_data = {apb.paddr[3:2], apb.pwdata};
    assign last_err        = last_err_q;

    always_comb begin
        state_d        = state_q;
        last_err_d     = last_err_q;
        apb.prdata     = '0;
        apb.pready     = 1'b0;
        apb.pslverr    = 1'b0;
        fifo_write_inc = 1'b0;
        fifo_read_inc  = 1'b0;
`ifdef APB_SL_TIMEOUT_EN
        wait_clr       = 1'b0;
        wait_inc       = 1'b0;
`endif
        unique case (state_q)
            StIdle: begin
                if (apb.psel && !apb.penable) begin
                    state_d = StAccess;
`ifdef APB_SL_TIMEOUT_EN
                    wait_clr = 1'b1;
`endif
                end
            end
            StAccess: begin
                if (!apb.psel) begin
                    state_d = StIdle;
                end else if (apb.penable) begin
                    if (apb.paddr[1:0] != 2'b00 || (apb.pwrite && apb.paddr[3:2] == MOD_STATUS)) begin
                        apb.pready  = 1'b1;
                        apb.pslverr = 1'b1;
                        last_err_d  = ERR_ILLEGAL;
                    end else if (apb.pwrite && !fifo_write_full) begin
                        fifo_write_inc = 1'b1;
                        apb.pready     = 1'b1;
                        last_err_d     = ERR_OK;
                    end else if (!apb.pwrite && !fifo_read_empty) begin
                        // The word is consumed even when its modifier does not match.
                        fifo_read_inc = 1'b1;
                        apb.prdata    = fifo_read_data[31:0];
                        apb.pready    = 1'b1;
                        if (fifo_read_data[HMB:LMB] != apb.paddr[3:2]) begin
                            apb.pslverr = 1'b1;
                            last_err_d  = ERR_MODIFIER;
                        end else begin
                            last_err_d  = ERR_OK;
                        end
                    end else begin
`ifdef APB_SL_TIMEOUT_EN
                        if (wait_done) begin
                            apb.pready  = 1'b1;
                            apb.pslverr = 1'b1;
                            last_err_d  = ERR_TIMEOUT;
                        end else begin
                            wait_inc = 1'b1;
                        end
`endif
                    end
                    if (apb.pready) begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            last_err_q <= ERR_OK;
        end else begin
            state_q    <= state_d;
            last_err_q <= last_err_d;
        end
    end

endmodule

// File: tb/tb_apb_sl_fifo_port.sv
// Scoreboard bench for apb_sl_fifo_port: directed and random APB transfers against a transfer-level model.
module tb_apb_sl_fifo_port;

    localparam int unsigned TIMEOUT = 4;
`ifdef APB_SL_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    typedef struct {
        bit          wr;
        bit          push;
        bit          pop;
        bit          slverr;
        bit          chk_prdata;
        logic [31:0] prdata;
        logic [33:0] wdata;
        logic [1:0]  code;
        int          waits;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        fifo_write_full;
    logic [33:0] fifo_write_data;
    logic        fifo_write_inc;
    logic        fifo_read_empty;
    logic [33:0] fifo_read_data;
    logic        fifo_read_inc;
    logic [1:0]  last_err;

    apb_sl_fifo_port_if apb ();

    apb_sl_fifo_port #(
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .apb             (apb),
        .fifo_write_full (fifo_write_full),
        .fifo_write_data (fifo_write_data),
        .fifo_write_inc  (fifo_write_inc),
        .fifo_read_empty (fifo_read_empty),
        .fifo_read_data  (fifo_read_data),
        .fifo_read_inc   (fifo_read_inc),
        .last_err        (last_err)
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];
    logic [1:0] exp_last = 2'd0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Transfer-level model: outcome depends only on address legality, when the FIFO becomes
    // usable (avail = unusable ACCESS cycles, -1 = never) and the timeout limit.
    function automatic exp_t model(input bit wr, input logic [3:0] addr, input logic [31:0] wdata,
                                   input logic [33:0] rword, input int avail);
        exp_t e;
        e.wr = wr; e.push = 0; e.pop = 0; e.slverr = 0; e.chk_prdata = 0;
        e.prdata = 32'd0; e.wdata = {addr[3:2], wdata}; e.code = 2'd0; e.waits = 0;
        if (addr[1:0] != 2'b00 || (wr && addr[3:2] == 2'd2)) begin
            e.slverr = 1; e.code = 2'd3;
        end else if (TO_EN && (avail < 0 || avail > int'(TIMEOUT))) begin
            e.waits = int'(TIMEOUT); e.slverr = 1; e.code = 2'd1; e.chk_prdata = 1;
        end else begin
            e.waits = avail;
            if (wr) begin
                e.push = 1;
            end else begin
                e.pop = 1; e.chk_prdata = 1; e.prdata = rword[31:0];
                if (rword[33:32] != addr[3:2]) begin
                    e.slverr = 1; e.code = 2'd2;
                end
            end
        end
        return e;
    endfunction

    task automatic set_avail(input bit wr, input int avail, input int k);
        logic busy;
        busy = (avail < 0 || k < avail);
        if (wr) begin
            fifo_write_full = busy;
            fifo_read_empty = 1'($urandom_range(0, 1));
        end else begin
            fifo_read_empty = busy;
            fifo_write_full = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic xfer(input bit wr, input logic [3:0] addr, input logic [31:0] wdata,
                        input logic [33:0] rword, input int avail);
        int  k;
        bit  done;
        exp_q.push_back(model(wr, addr, wdata, rword, avail));
        @(posedge clk); #1;
        apb.psel = 1; apb.penable = 0; apb.pwrite = wr; apb.paddr = addr; apb.pwdata = wdata;
        fifo_read_data = rword;
        set_avail(wr, -1, 0);
        @(posedge clk); #1;
        apb.penable = 1;
        k = 0;
        done = 0;
        set_avail(wr, avail, k);
        while (!done && k < 1000) begin
            @(negedge clk);
            done = apb.pready;
            if (!done) begin
                @(posedge clk); #1;
                k++;
                set_avail(wr, avail, k);
            end
        end
        if (!done) begin
            chk("xfer_timeout", 64'(k), 64'd0);
        end
        @(posedge clk); #1;
        apb.psel = 0; apb.penable = 0;
        set_avail(wr, -1, 0);
    endtask

    // Monitor: pops one expectation per completing cycle; checks last_err on the following cycle.
    int   wait_cnt = 0;
    bit   err_pending = 0;
    logic [1:0] err_exp;

    always @(negedge clk) begin
        exp_t e;
        if (err_pending && !rst) begin
            chk("last_err", 64'(last_err), 64'(err_exp));
        end
        err_pending = 0;
        if (rst || !apb.psel) begin
            wait_cnt = 0;
        end
        if (!apb.pready) begin
            chk("quiet_outputs", {apb.prdata, 28'd0, apb.pslverr, fifo_write_inc, fifo_read_inc, 1'b0},
                64'd0);
            if (apb.psel && apb.penable && !rst) wait_cnt++;
        end else if (exp_q.size() == 0) begin
            chk("unexpected_completion", 64'd1, 64'd0);
        end else begin
            e = exp_q.pop_front();
            chk("wait_states", 64'(wait_cnt), 64'(e.waits));
            chk("pslverr", 64'(apb.pslverr), 64'(e.slverr));
            chk("write_inc", 64'(fifo_write_inc), 64'(e.push));
            chk("read_inc", 64'(fifo_read_inc), 64'(e.pop));
            if (e.push) chk("write_data", 64'(fifo_write_data), 64'(e.wdata));
            if (e.chk_prdata) chk("prdata", 64'(apb.prdata), 64'(e.prdata));
            err_pending = 1;
            err_exp = e.code;
            exp_last = e.code;
            wait_cnt = 0;
        end
    end

    initial begin
        logic [3:0] a;
        bit         wr;
        int         av;
        rst = 1;
        apb.psel = 0; apb.penable = 0; apb.pwrite = 0; apb.paddr = 0; apb.pwdata = 0;
        fifo_write_full = 0; fifo_read_empty = 1; fifo_read_data = 0;
        #2;
        chk("reset_outputs", {apb.prdata, 29'd0, apb.pready, apb.pslverr, fifo_write_inc | fifo_read_inc},
            64'd0);
        chk("reset_last_err", 64'(last_err), 64'd0);
        @(posedge clk); #1 rst = 0;

        xfer(1, 4'h4, 32'hDEADBEEF, 34'h0, 0);
        xfer(1, 4'h0, 32'h12345678, 34'h0, 3);
        xfer(0, 4'h8, 32'h0, 34'h2_00000055, 0);
        xfer(0, 4'h0, 32'h0, 34'h3_00000001, 0);
        if (TO_EN) begin
            xfer(0, 4'h0, 32'h0, 34'h0_0000AAAA, -1);
            xfer(0, 4'h0, 32'h0, 34'h0_0000BBBB, int'(TIMEOUT));
        end
        xfer(1, 4'h8, 32'hCAFEF00D, 34'h0, 0);
        xfer(0, 4'h6, 32'h0, 34'h1_00000077, 0);

        // Abort: psel drops mid-wait; nothing is pushed and last_err holds.
        @(posedge clk); #1;
        apb.psel = 1; apb.penable = 0; apb.pwrite = 1; apb.paddr = 4'h4; fifo_write_full = 1;
        @(posedge clk); #1 apb.penable = 1;
        repeat (2) @(posedge clk);
        #1 apb.psel = 0; apb.penable = 0;
        @(posedge clk); #1;
        chk("abort_last_err", 64'(last_err), 64'(exp_last));

        // Reset during a wait state with the command FIFO full.
        apb.psel = 1; apb.penable = 0; apb.pwrite = 1; apb.paddr = 4'h0; fifo_write_full = 1;
        @(posedge clk); #1 apb.penable = 1;
        repeat (2) @(posedge clk);
        #3 rst = 1;
        #1;
        chk("midreset_outputs",
            {apb.prdata, 29'd0, apb.pready, apb.pslverr, fifo_write_inc | fifo_read_inc}, 64'd0);
        chk("midreset_last_err", 64'(last_err), 64'd0);
        exp_last = 2'd0;
        apb.psel = 0; apb.penable = 0;
        @(posedge clk); #1 rst = 0;
        xfer(1, 4'hC, 32'h0BADF00D, 34'h0, 0);

        for (int i = 0; i < 150; i++) begin
            wr = 1'($urandom_range(0, 1));
            a = {2'($urandom_range(0, 3)), 2'b00};
            if ($urandom_range(0, 7) == 0) a[1:0] = 2'($urandom_range(1, 3));
            av = $urandom_range(0, 6);
            if (TO_EN && $urandom_range(0, 7) == 0) av = -1;
            xfer(wr, a, $urandom, {2'($urandom_range(0, 3)), 32'($urandom)}, av);
        end

        repeat (3) @(posedge clk);
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/apb_sl_fifo_port.md
Name: apb_sl_fifo_port

Overview:
- APB3 slave end of the SL transceiver command/response path.
- Turns APB writes into 34-bit {modifier, data} command words pushed into the command FIFO.
- Turns APB reads into pops from the response FIFO, which the channel-side bridge consumes and fills.
- Sits between the system APB bus and the two SL FIFOs; it is the bus-side counterpart of the FIFO-to-TX/RX register bridge.

Parameters:
TIMEOUT, 255, maximum number of wait-state cycles in ACCESS before an error completion (must be ≥1).
TO_W, $clog2(TIMEOUT+1), width of the wait counter (derived; do not override).

Ports:
clk  input  1  single clock.
rst  input  1  asynchronous, active-high reset.
psel  input  1  APB select.
penable  input  1  APB enable.
pwrite  input  1  APB direction (1 = write).
paddr  input  4  byte address; [3:2] = modifier, [1:0] must be 0.
pwdata  input  32  APB write data.
prdata  output  32  APB read data.
pready  output  1  APB ready.
pslverr  output  1  APB error, valid only with pready.
fifo_write_full  input  1  command FIFO full.
fifo_write_data  output  34  command word {modifier[1:0], data[31:0]}.
fifo_write_inc  output  1  command FIFO push strobe.
fifo_read_empty  input  1  response FIFO empty.
fifo_read_data  input  34  response word (first-word-fall-through).
fifo_read_inc  output  1  response FIFO pop strobe.
last_err  output  2  code of the last completed transfer: 0 ok, 1 timeout, 2 modifier mismatch, 3 illegal access.

Behaviour:
- Modifiers: CONFIG=0, DATA=1, STATUS=2, CHANNEL=3. Word layout: modifier in [33:32], data in [31:0].
- FSM states: IDLE, ACCESS.
  - IDLE→ACCESS when psel=1 and penable=0 (setup phase).
  - ACCESS→IDLE on completion (pready=1), or when psel=0 (abort: no FIFO action, last_err unchanged).
  - The wait counter clears on entry to ACCESS.
- Completion is decided combinationally in ACCESS when psel=1 and penable=1, in this priority order:
  1. paddr[1:0]≠0, or a write to STATUS: pready=1, pslverr=1, code 3, no FIFO action.
  2. Write with fifo_write_full=0: fifo_write_inc=1, fifo_write_data={paddr[3:2], pwdata}, pready=1, pslverr=0.
  3. Read with fifo_read_empty=0: fifo_read_inc=1 (word always consumed), prdata=fifo_read_data[31:0], pready=1.
     - If fifo_read_data[33:32]≠paddr[3:2]: pslverr=1, code 2.
  4. Resource unavailable and counter=TIMEOUT: pready=1, pslverr=1, prdata=0, code 1, no FIFO action.
  5. Otherwise: pready=0 and the counter increments (saturating).
- A resource becoming available in the same cycle the timeout is reached wins; the transfer completes normally.
- Timing: zero wait states when the resource is available; at most TIMEOUT+1 ACCESS cycles per transfer.
- fifo_write_inc and fifo_read_inc are single-cycle strobes, at most one per transfer, never both in one cycle.
- last_err is registered and updates on the clock edge where a transfer completes.
- Outputs outside a completing ACCESS cycle: prdata=0, pready=0, pslverr=0, both strobes 0. fifo_write_data={paddr[3:2], pwdata}, used only with fifo_write_inc.
- Reset (asynchronous, any time including mid-transfer): state IDLE, counter 0, last_err 0, all strobes and APB outputs 0. An aborted transfer pushes or pops nothing.

Optional Feature:
Macro APB_SL_TIMEOUT_EN.
- Defined: timeout rule 4 is active as described above.
- Undefined: no wait counter is instantiated; ACCESS waits indefinitely for the resource; last_err code 1 is never produced.

Decomposition:
- Shared package sl_fifo_pkg holds:
  - modifier constants CONFIG/DATA/STATUS/CHANNEL;
  - HMB=33, LMB=32, word width 34;
  - error code constants;
  - the FSM state typedef.
- The channel-side bridge imports the same package.
- One natural sub-module, apb_sl_wait_timer: the clear, increment and terminal-count counter, compiled only under APB_SL_TIMEOUT_EN.

Test Plan:
- Write paddr=0x4, pwdata=0xDEADBEEF, FIFO not full → one fifo_write_inc, data 0x1_DEADBEEF, pready in the first ACCESS cycle, last_err=0.
- Write paddr=0x0 with fifo_write_full=1 for 3 cycles, then 0 → 3 wait states, push on the 4th ACCESS cycle, pslverr=0.
- Read paddr=0x8, response word 0x2_00000055 → prdata=0x00000055, one fifo_read_inc, pslverr=0; then read paddr=0x0 with word 0x3_00000001 → popped, pslverr=1, last_err=2.
- TIMEOUT=4, read with fifo_read_empty held 1 → pready and pslverr on the 5th ACCESS cycle, prdata=0, no pop, last_err=1. Repeat with empty dropping on the 5th cycle → normal read.
- Write to paddr=0x8 and access to paddr=0x6 → immediate pslverr, no FIFO strobe, last_err=3.
- Assert rst during a wait state with the FIFO full → all outputs 0, last_err=0, no push. The next transfer completes normally.
